// File: rtl/axis_fifo_if.sv
// AXI-Stream link carrying tvalid/tready/tdata; s is the write side, m the read side.
interface axis_if #(
  parameter int TDATA_WIDTH = 8
) ();
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;

  modport s (input tvalid, output tready, input tdata);
  modport m (output tvalid, input tready, output tdata);
endinterface

// File: rtl/axis_fifo.sv
// Synchronous AXI-Stream FIFO feeding a downstream register slice.
// Define AXIS_FIFO_HWM_EN to add the hwm (peak occupancy since reset) output.
module axis_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  axis_if.s                      axis_sif,
  axis_if.m                      axis_mif,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
`ifdef AXIS_FIFO_HWM_EN
  ,
  output logic [$clog2(DEPTH):0] hwm
`endif
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int TDATA_WIDTH = axis_sif.TDATA_WIDTH;
  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "axis_fifo: DEPTH must be a power of two >= 2");
  end
  if (axis_mif.TDATA_WIDTH != TDATA_WIDTH) begin : g_bad_width
    $fatal(1, "axis_fifo: axis_sif and axis_mif TDATA_WIDTH differ");
  end

  logic [TDATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]        cnt_q, cnt_d;
  logic                   push, pop;

  assign axis_sif.tready = !flush && (cnt_q != FULL);
  assign axis_mif.tvalid = (cnt_q != '0);
  assign axis_mif.tdata  = mem_q[rd_ptr_q];
  assign count           = cnt_q;

  assign push = axis_sif.tvalid && axis_sif.tready;
  assign pop  = axis_mif.tvalid && axis_mif.tready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is deliberately left unreset; cnt alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= axis_sif.tdata;
  end

`ifdef AXIS_FIFO_HWM_EN
  logic [ADDR_W:0] hwm_q, hwm_d;

  assign hwm_d = (cnt_d > hwm_q) ? cnt_d : hwm_q;
  assign hwm   = hwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hwm_q <= '0;
    else        hwm_q <= hwm_d;
  end
`endif
endmodule

// File: tb/tb_axis_fifo.sv
// Directed self-checking bench for axis_fifo (DEPTH=8, 8-bit tdata).
module tb_axis_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] count;
`ifdef AXIS_FIFO_HWM_EN
  logic [3:0] hwm;
`endif
  int checks = 0;
  int failures = 0;

  axis_if #(.TDATA_WIDTH(8)) s_if ();
  axis_if #(.TDATA_WIDTH(8)) m_if ();

  axis_fifo #(.DEPTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .axis_sif (s_if),
    .axis_mif (m_if),
    .flush    (flush),
    .count    (count)
`ifdef AXIS_FIFO_HWM_EN
    ,
    .hwm      (hwm)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    s_if.tvalid = 1'b0;
    s_if.tdata  = 8'h00;
    m_if.tready = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++;
    if (s_if.tready !== 1'b1) begin failures++; $display("[TB] FAIL reset_tready got=%b exp=1", s_if.tready); end
    checks++;
    if (m_if.tvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_tvalid got=%b exp=0", m_if.tvalid); end
    checks++;
    if (count !== 4'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_full();
    logic [7:0] exp_q [$];
    logic       pushed;
    m_if.tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'h11 + 8'(i);
      tick();
    end
    checks++;
    if (count !== 4'd8) begin failures++; $display("[TB] FAIL full_count got=%0d exp=8", count); end
    checks++;
    if (s_if.tready !== 1'b0) begin failures++; $display("[TB] FAIL full_tready got=%b exp=0", s_if.tready); end
    s_if.tdata = 8'h19;
    tick();
    tick();
    checks++;
    if (count !== 4'd8) begin failures++; $display("[TB] FAIL full_hold_count got=%0d exp=8", count); end
    for (int i = 0; i < 9; i++) exp_q.push_back(8'h11 + 8'(i));
    m_if.tready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (m_if.tvalid !== 1'b1 || m_if.tdata !== exp_q[i]) begin
        failures++;
        $display("[TB] FAIL drain_beat%0d got=%b/%h exp=1/%h", i, m_if.tvalid, m_if.tdata, exp_q[i]);
      end
      pushed = s_if.tvalid && s_if.tready;
      tick();
      if (pushed) s_if.tvalid = 1'b0;
    end
    checks++;
    if (count !== 4'd0 || m_if.tvalid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL drain_empty got=%0d/%b exp=0/0", count, m_if.tvalid);
    end
    m_if.tready = 1'b0;
  endtask

  task automatic test_back_to_back();
    m_if.tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'(i);
      tick();
      checks++;
      if (m_if.tvalid !== 1'b1 || m_if.tdata !== 8'(i) || count !== 4'd1) begin
        failures++;
        $display("[TB] FAIL stream_beat%0d got=%b/%h/%0d exp=1/%h/1", i, m_if.tvalid, m_if.tdata, count, 8'(i));
      end
    end
    s_if.tvalid = 1'b0;
    tick();
    checks++;
    if (count !== 4'd0) begin failures++; $display("[TB] FAIL stream_end_count got=%0d exp=0", count); end
    m_if.tready = 1'b0;
  endtask

  task automatic test_push_pop_at_four();
    m_if.tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'h40 + 8'(i);
      tick();
    end
    checks++;
    if (count !== 4'd4 || m_if.tdata !== 8'h40) begin
      failures++;
      $display("[TB] FAIL four_load got=%0d/%h exp=4/40", count, m_if.tdata);
    end
    s_if.tdata  = 8'h44;
    m_if.tready = 1'b1;
    tick();
    checks++;
    if (count !== 4'd4 || m_if.tdata !== 8'h41) begin
      failures++;
      $display("[TB] FAIL four_pushpop got=%0d/%h exp=4/41", count, m_if.tdata);
    end
    s_if.tvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (m_if.tvalid !== 1'b1 || m_if.tdata !== 8'h41 + 8'(i)) begin
        failures++;
        $display("[TB] FAIL four_drain%0d got=%b/%h exp=1/%h", i, m_if.tvalid, m_if.tdata, 8'h41 + 8'(i));
      end
      tick();
    end
    checks++;
    if (count !== 4'd0) begin failures++; $display("[TB] FAIL four_end_count got=%0d exp=0", count); end
    m_if.tready = 1'b0;
  endtask

  task automatic test_flush();
    m_if.tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'h50 + 8'(i);
      tick();
    end
    flush = 1'b1;
    s_if.tdata = 8'hAA;
    #1;
    checks++;
    if (s_if.tready !== 1'b0) begin failures++; $display("[TB] FAIL flush_tready got=%b exp=0", s_if.tready); end
    tick();
    flush = 1'b0;
    s_if.tvalid = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0 || m_if.tvalid !== 1'b0 || s_if.tready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_state got=%0d/%b/%b exp=0/0/1", count, m_if.tvalid, s_if.tready);
    end
    s_if.tvalid = 1'b1;
    s_if.tdata  = 8'h5A;
    tick();
    s_if.tvalid = 1'b0;
    checks++;
    if (count !== 4'd1 || m_if.tdata !== 8'h5A) begin
      failures++;
      $display("[TB] FAIL flush_after got=%0d/%h exp=1/5a", count, m_if.tdata);
    end
    m_if.tready = 1'b1;
    tick();
    m_if.tready = 1'b0;
  endtask

  task automatic test_reset_mid();
    m_if.tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'h60 + 8'(i);
      tick();
    end
    s_if.tvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0 || m_if.tvalid !== 1'b0 || s_if.tready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset got=%0d/%b/%b exp=0/0/1", count, m_if.tvalid, s_if.tready);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

`ifdef AXIS_FIFO_HWM_EN
  task automatic test_hwm();
    m_if.tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'h70 + 8'(i);
      tick();
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    m_if.tready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (hwm !== 4'd6) begin failures++; $display("[TB] FAIL hwm_after_flush got=%0d exp=6", hwm); end
    for (int i = 0; i < 3; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'h80 + 8'(i);
      tick();
    end
    s_if.tvalid = 1'b0;
    checks++;
    if (hwm !== 4'd6 || count !== 4'd3) begin
      failures++;
      $display("[TB] FAIL hwm_refill got=%0d/%0d exp=6/3", hwm, count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_full();
    test_back_to_back();
    test_push_pop_at_four();
    test_flush();
    test_reset_mid();
`ifdef AXIS_FIFO_HWM_EN
    checks++;
    if (hwm !== 4'd0) begin failures++; $display("[TB] FAIL hwm_reset got=%0d exp=0", hwm); end
    test_hwm();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
